// File: rtl/onchip_rom_burst_bridge.sv
// Purpose : Avalon-MM burst slave front-end for a 1-cycle-latency on-chip ROM/RAM macro;
//           splits byte-addressed burst reads into sequential word accesses, forwards debug writes.
// Latency : command accepted at edge T, ROM address driven in the following cycle, readdatavalid one cycle later.
// Backpr. : s_waitrequest holds off commands during a burst (released on its last issue) and for the write cycle;
//           the response path has no backpressure.
//
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   s_address/s_burstcount        - byte address (bits [1:0] ignored) and beat count (0 treated as 1)
//   s_read/s_write                - commands; read wins when both are asserted
//   s_writedata/s_byteenable      - single-beat write payload
//   s_debugaccess                 - write qualifier forwarded to the macro
//   s_waitrequest                 - command not accepted this cycle
//   s_readdata/s_readdatavalid    - read response, one beat per cycle
//   m_*                           - ROM macro side (word address, strobes, write payload)
//   m_readdata                    - unregistered macro output, valid the cycle after address issue

module onchip_rom_burst_bridge #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 10240,
  parameter int BURST_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W+1:0] s_address,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  input  logic [3:0]        s_byteenable,
  input  logic              s_debugaccess,
  output logic              s_waitrequest,
  output logic [31:0]       s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_clken,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_debugaccess,
  input  logic [31:0]       m_readdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR       = 2'd2
  } state_t;

  // One extra bit so the range check stays correct even if DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;      // address being issued this cycle (drives m_address)
  logic [BURST_W-1:0]   cnt_q;       // beats left to issue, including the current one
  logic                 zf_q;        // whole burst is out of range: return zeros, no strobe
  logic                 cs_q;
  logic                 wr_q;
  logic [31:0]          wdat_q;
  logic [3:0]           be_q;
  logic                 dbg_q;
  logic                 wait_q;
  logic                 rdv_q;       // issue of previous cycle -> beat on the response path now
  logic                 rdz_q;       // that beat was zero-forced

  // Command decode, shared by IDLE and the last-issue cycle of a burst.
  logic [ADDR_W-1:0]    cmd_word;
  logic                 cmd_oor;
  logic [BURST_W-1:0]   cmd_cnt;
  logic                 acc_rd;
  logic                 acc_wr;
  logic                 mid_burst;
  logic [ADDR_W-1:0]    addr_inc;
  logic                 unused_addr_lsb;

  assign cmd_word  = s_address[ADDR_W+1:2];
  assign cmd_oor   = {1'b0, cmd_word} >= DEPTH_X;
  assign cmd_cnt   = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
  assign acc_rd    = s_read & ~wait_q;
  assign acc_wr    = s_write & ~s_read & ~wait_q;
  assign mid_burst = (state_q == RD_BURST) && (cnt_q != BURST_W'(1));
  // Word addresses wrap modulo DEPTH, not modulo 2**ADDR_W.
  assign addr_inc  = (addr_q == LAST_WORD) ? '0 : addr_q + ADDR_W'(1);

  // Byte-lane bits never reach the word-addressed macro.
  assign unused_addr_lsb = ^s_address[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      be_q    <= 4'hF;
      dbg_q   <= 1'b0;
      wait_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdz_q   <= 1'b0;
    end else begin
      // The macro captures the address at this edge, so its q is valid next cycle.
      rdv_q <= (state_q == RD_BURST);
      rdz_q <= zf_q;

      if (mid_burst) begin
        // Keep streaming; release waitrequest for the cycle that issues the final beat.
        addr_q <= addr_inc;
        cnt_q  <= cnt_q - BURST_W'(1);
        wait_q <= (cnt_q != BURST_W'(2));
      end else if (acc_rd) begin
        // Reached from IDLE or from the last-issue cycle: the new burst follows with no gap.
        state_q <= RD_BURST;
        addr_q  <= cmd_word;
        cnt_q   <= cmd_cnt;
        zf_q    <= cmd_oor;
        cs_q    <= ~cmd_oor;
        wr_q    <= 1'b0;
        be_q    <= 4'hF;
        dbg_q   <= 1'b0;
        wait_q  <= (cmd_cnt != BURST_W'(1));
      end else if (acc_wr) begin
        // Out-of-range writes still take the WR cycle but never strobe the macro.
        state_q <= WR;
        addr_q  <= cmd_word;
        zf_q    <= 1'b0;
        cs_q    <= ~cmd_oor;
        wr_q    <= 1'b1;
        wdat_q  <= s_writedata;
        be_q    <= s_byteenable;
        dbg_q   <= s_debugaccess;
        wait_q  <= 1'b1;
      end else begin
        // WR always lands here (wait_q blocks any accept), as does an idle last-issue cycle.
        state_q <= IDLE;
        zf_q    <= 1'b0;
        cs_q    <= 1'b0;
        wr_q    <= 1'b0;
        be_q    <= 4'hF;
        dbg_q   <= 1'b0;
        wait_q  <= 1'b0;
      end
    end
  end

  assign s_waitrequest   = wait_q;
  assign s_readdatavalid = rdv_q;
  // Gated so the bus reads zero outside valid beats and for out-of-range beats.
  assign s_readdata      = (rdv_q && !rdz_q) ? m_readdata : 32'h0;

  assign m_address     = addr_q;
  assign m_chipselect  = cs_q;
  assign m_clken       = 1'b1;
  assign m_write       = wr_q;
  assign m_writedata   = wdat_q;
  assign m_byteenable  = be_q;
  assign m_debugaccess = dbg_q;

endmodule

// File: tb/tb_onchip_rom_burst_bridge.sv
module tb_onchip_rom_burst_bridge;

  localparam int ADDR_W  = 14;
  localparam int DEPTH   = 10240;
  localparam int BURST_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W+1:0] s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic              s_read;
  logic              s_write;
  logic [31:0]       s_writedata;
  logic [3:0]        s_byteenable;
  logic              s_debugaccess;
  logic              s_waitrequest;
  logic [31:0]       s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_clken;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_debugaccess;
  logic [31:0]       m_readdata;

  onchip_rom_burst_bridge #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_debugaccess(s_debugaccess),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_clken(m_clken), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_debugaccess(m_debugaccess),
    .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // ROM macro stand-in (written only by the DUT) and the bench's golden copy.
  logic [31:0] rom  [0:DEPTH-1];
  logic [31:0] gold [0:DEPTH-1];
  logic [31:0] rom_q = 32'h0;
  assign m_readdata = rom_q;

  always @(posedge clk) begin
    if (m_chipselect && m_clken && (int'(m_address) < DEPTH)) begin
      if (m_write && m_debugaccess) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) rom[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end
      rom_q <= rom[m_address];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues: expected read data per beat and expected issued word address.
  logic [31:0]       dq [$];
  logic [ADDR_W-1:0] aq [$];

  int run = 0, last_run = 0, wait_hi = 0, wr_pulses = 0, cs_seen = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
    end else begin
      if (s_readdatavalid) begin
        chk("beat_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) chk("rdata", s_readdata, dq.pop_front());
        run++;
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (m_chipselect && !m_write) begin
        cs_seen++;
        chk("issue_expected", 32'(aq.size() != 0), 32'd1);
        if (aq.size() != 0) chk("m_address", 32'(m_address), 32'(aq.pop_front()));
      end
      if (m_write) wr_pulses++;
      if (s_waitrequest) wait_hi++;
    end
  end

  // All tasks start and end at #1 after a rising edge.
  task automatic do_read(input int word, input int bc);
    int n = 0;
    int beats = (bc == 0) ? 1 : bc;
    s_address    = 16'(word * 4);
    s_burstcount = 5'(bc);
    s_read       = 1'b1;
    while (s_waitrequest && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("read_accept_timeout", 32'(n < 50), 32'd1);
    for (int b = 0; b < beats; b++) begin
      if (word >= DEPTH) begin
        dq.push_back(32'h0);
      end else begin
        int a = (word + b) % DEPTH;
        aq.push_back(14'(a));
        dq.push_back(gold[a]);
      end
    end
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic do_write(input int word, input logic [31:0] d, input logic [3:0] be, input logic dbg);
    int n = 0;
    s_address     = 16'(word * 4);
    s_burstcount  = 5'd3;
    s_writedata   = d;
    s_byteenable  = be;
    s_debugaccess = dbg;
    s_write       = 1'b1;
    while (s_waitrequest && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("write_accept_timeout", 32'(n < 50), 32'd1);
    if (dbg && word < DEPTH)
      for (int b = 0; b < 4; b++)
        if (be[b]) gold[word][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((dq.size() != 0 || aq.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i]  = 32'(i) * 32'h9E3779B1 + 32'h1234;
      gold[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
    end
    reset_n = 1'b0; s_address = '0; s_burstcount = '0; s_read = 1'b0; s_write = 1'b0;
    s_writedata = '0; s_byteenable = '0; s_debugaccess = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset state
    chk("rst_waitrequest", 32'(s_waitrequest), 32'd0);
    chk("rst_rdvalid", 32'(s_readdatavalid), 32'd0);
    chk("rst_rdata", s_readdata, 32'h0);
    chk("rst_cs", 32'(m_chipselect), 32'd0);
    chk("rst_mwrite", 32'(m_write), 32'd0);
    chk("rst_maddr", 32'(m_address), 32'd0);
    chk("rst_be", 32'(m_byteenable), 32'hF);
    chk("rst_dbg", 32'(m_debugaccess), 32'd0);
    chk("rst_wdata", m_writedata, 32'h0);
    chk("clken", 32'(m_clken), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single read at byte 0x10: issue right after accept, valid one cycle later for one cycle
    do_read(4, 1);
    chk("single_issue_cs", 32'(m_chipselect), 32'd1);
    chk("single_issue_addr", 32'(m_address), 32'd4);
    chk("single_not_yet_valid", 32'(s_readdatavalid), 32'd0);
    @(posedge clk); #1;
    chk("single_valid", 32'(s_readdatavalid), 32'd1);
    chk("single_data", s_readdata, gold[4]);
    @(posedge clk); #1;
    chk("single_valid_drop", 32'(s_readdatavalid), 32'd0);
    drain();

    // Burst of 16 from byte 0x100
    wait_hi = 0;
    do_read(64, 16);
    drain();
    chk("burst16_contig", 32'(last_run), 32'd16);
    chk("burst16_wait_cycles", 32'(wait_hi), 32'd15);

    // Burstcount 0 treated as 1
    do_read(300, 0);
    drain();
    chk("bc0_run", 32'(last_run), 32'd1);

    // Wrap at DEPTH
    do_read(10238, 4);
    drain();
    chk("wrap_contig", 32'(last_run), 32'd4);

    // Out of range: zero beats, no strobe
    cs_seen = 0;
    do_read(12000, 3);
    drain();
    chk("oor_no_cs", 32'(cs_seen), 32'd0);
    chk("oor_contig", 32'(last_run), 32'd3);

    // Back-to-back bursts, second accepted on the last-issue cycle
    do_read(10, 2);
    do_read(20, 2);
    drain();
    chk("b2b_contig", 32'(last_run), 32'd4);

    // Debug write, then read back
    wr_pulses = 0;
    do_write(5, 32'hA5A5A5A5, 4'b0011, 1'b1);
    chk("wr_mwrite", 32'(m_write), 32'd1);
    chk("wr_cs", 32'(m_chipselect), 32'd1);
    chk("wr_addr", 32'(m_address), 32'd5);
    chk("wr_data", m_writedata, 32'hA5A5A5A5);
    chk("wr_be", 32'(m_byteenable), 32'h3);
    chk("wr_dbg", 32'(m_debugaccess), 32'd1);
    chk("wr_busy", 32'(s_waitrequest), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("wr_pulses", 32'(wr_pulses), 32'd1);
    chk("wr_gold_low_half", gold[5], {rom[5][31:16], 16'hA5A5});
    do_read(5, 1);
    drain();

    // Reset mid-burst
    do_read(100, 16);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_pre_valid", 32'(s_readdatavalid), 32'd1);
    reset_n = 1'b0;
    dq.delete();
    aq.delete();
    #1;
    chk("midrst_valid_drop", 32'(s_readdatavalid), 32'd0);
    chk("midrst_cs_drop", 32'(m_chipselect), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_wait", 32'(s_waitrequest), 32'd0);
    do_read(7, 2);
    drain();
    chk("postrst_contig", 32'(last_run), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_rom_burst_bridge.md
Name: onchip_rom_burst_bridge

Overview:
- Avalon-MM burst-capable slave front-end that sits directly upstream of the on-chip ROM/RAM macro (32-bit data, 14-bit word address, 10240 words, 1-cycle read latency).
- Converts byte-addressed burst reads from the system interconnect into sequential single-word ROM accesses and generates readdatavalid.
- Forwards single-beat debug writes. Hides ROM latency from the master and keeps back-to-back bursts gap-free.

Parameters:
- ADDR_W, 14, ROM word-address width.
- DEPTH, 10240, ROM depth in words; word addresses wrap modulo DEPTH.
- BURST_W, 5, burstcount width (max burst 16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  ADDR_W+2  byte address; bits [1:0] ignored.
- s_burstcount  in  BURST_W  beats requested, 1..16.
- s_read  in  1  read command.
- s_write  in  1  write command, single beat only.
- s_writedata  in  32  write data.
- s_byteenable  in  4  write byte enables.
- s_debugaccess  in  1  debug qualifier for writes.
- s_waitrequest  out  1  command not accepted this cycle.
- s_readdata  out  32  read data.
- s_readdatavalid  out  1  s_readdata valid this cycle.
- m_address  out  ADDR_W  ROM word address.
- m_chipselect  out  1  ROM access strobe.
- m_clken  out  1  ROM clock enable.
- m_write  out  1  ROM write.
- m_writedata  out  32  ROM write data.
- m_byteenable  out  4  ROM byte enables.
- m_debugaccess  out  1  ROM debug qualifier.
- m_readdata  in  32  ROM output (unregistered q, valid the cycle after address issue).

Behaviour:
- Reset (async assert, sync release): state IDLE; s_waitrequest=0, s_readdatavalid=0, s_readdata=0, m_chipselect=0, m_write=0, m_address=0, m_byteenable=4'hF, m_debugaccess=0, m_writedata=0. m_clken is constant 1.
- A command is accepted on a rising edge when (s_read|s_write) & !s_waitrequest.
- If s_read and s_write are asserted together, the read wins and the write is dropped.
- If s_burstcount=0, it is treated as 1.
- FSM states: IDLE, RD_BURST, WR.
- IDLE + read accepted:
  - latch word address = s_address[ADDR_W+1:2], latch count = burstcount, go to RD_BURST.
  - If the latched address >= DEPTH, set a zero-force flag for the whole burst. Beats still return, with data 0, and m_chipselect stays low.
- RD_BURST, each cycle:
  - m_address = current addr; m_chipselect = !zero_force; m_write=0.
  - addr increments; DEPTH-1 wraps to 0.
  - count decrements.
  - When count==1 (last issue), s_waitrequest=0 so a new command can be accepted this cycle. The next burst then issues on the following cycle with no gap. Otherwise the state returns to IDLE.
- s_waitrequest=1 throughout RD_BURST except the last-issue cycle, and throughout WR.
- Read response:
  - issue-valid is registered one cycle, and s_readdatavalid = that register.
  - s_readdata is combinationally m_readdata, or 0 when the beat was zero-forced.
  - Latency: accept edge T -> issue cycle T+1 -> first s_readdatavalid cycle T+2. N beats return on consecutive cycles.
- IDLE + write accepted:
  - latch address/data/byteenable/debugaccess, go to WR.
  - WR lasts one cycle: m_chipselect=1, m_write=1, m_debugaccess=latched value, then return to IDLE.
  - The bridge always completes the write. The ROM ignores it when debugaccess=0.
  - A write whose address is >= DEPTH is dropped (m_chipselect=0).
  - Write burstcount is ignored.
- No backpressure exists on the response path, and at most one beat is in flight per cycle, so no buffering is required.
- Reset mid-burst: outstanding beats are discarded and s_readdatavalid drops immediately on reset assertion.

Test Plan:
- Reset, then single read: byte addr 0x0010, burstcount 1 -> m_address=4 issued at T+1; s_readdatavalid one cycle at T+2 with ROM word 4.
- Burst of 16 from byte addr 0x0100 -> m_address 64..79 on consecutive cycles; 16 contiguous valid beats; s_waitrequest high for 15 cycles.
- Wrap: burst 4 at word 10238 -> addresses 10238, 10239, 0, 1, data matches ROM.
- Out of range: read at word 12000, burst 3 -> m_chipselect never asserted; 3 beats of 0x00000000.
- Back-to-back: burst 2 at word 10, then burst 2 at word 20 accepted on the last-issue cycle -> addresses 10, 11, 20, 21 gap-free, 4 contiguous valid beats.
- Write with debugaccess=1: addr word 5, data 0xA5A5A5A5, byteenable 4'b0011 -> one m_write pulse, then a read of word 5 returns the low half updated. Assert reset_n low mid-burst -> s_readdatavalid=0 immediately; after release the bridge is in IDLE.
